// File: rtl/apu_pkg.sv
// apu_pkg: sweep register layout and register address map shared by the pulse channel
package apu_pkg;
  typedef struct packed {
    logic       enable;
    logic [2:0] div_period;
    logic       negate;
    logic [2:0] shift;
  } sweep_cfg_t;
  localparam logic [1:0] ADDR_SWEEP     = 2'd1;
  localparam logic [1:0] ADDR_PERIOD_LO = 2'd2;
  localparam logic [1:0] ADDR_PERIOD_HI = 2'd3;
endpackage

// File: rtl/apu_sweep_unit.sv
// apu_sweep_unit: sweep target, mute and half-frame divider for one pulse channel
module apu_sweep_unit
  import apu_pkg::*;
#(
  parameter int PULSE_CH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        half_frame,
  input  logic        cfg_we,
  input  sweep_cfg_t  cfg,
  input  logic [10:0] period,
  output logic        update,
  output logic [10:0] target,
  output logic        mute
);
  logic [2:0]  divider;
  logic        reload;
  logic [10:0] change;
  logic [11:0] sum;
  always_comb begin
    change = period >> cfg.shift;
    sum    = cfg.negate ? {1'b0, period} - {1'b0, change} - ((PULSE_CH == 1) ? 12'd1 : 12'd0)
                        : {1'b0, period} + {1'b0, change};
    target = sum[10:0];
    mute   = (period < 11'd8) | (!cfg.negate & sum[11]);
    update = cpu_en & half_frame & (divider == 3'd0) & cfg.enable & (cfg.shift != 3'd0) & !mute;
  end
  // a sweep write landing on a half-frame keeps reload pending for the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      divider <= 3'd0;
      reload  <= 1'b0;
    end else if (cpu_en) begin
      if (half_frame)
        divider <= (divider == 3'd0 || reload) ? cfg.div_period : divider - 3'd1;
      reload <= cfg_we | (reload & !half_frame);
    end
  end
endmodule

// File: rtl/pulse_sweep_timer.sv
// pulse_sweep_timer: pulse channel period timer with optional sweep unit
// Sweep is built only when APU_PULSE_SWEEP_EN is defined.
module pulse_sweep_timer
  import apu_pkg::*;
#(
  parameter int PULSE_CH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        apu_cycle,
  input  logic        half_frame,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic        next_step,
  output logic        seq_reset,
  output logic        mute,
  output logic [10:0] period
);
  logic [10:0] timer;
  logic [10:0] target;
  logic [10:0] base;
  logic        upd;
  logic        wr_lo;
  logic        wr_hi;
  assign wr_lo     = cpu_en & reg_we & (reg_addr == ADDR_PERIOD_LO);
  assign wr_hi     = cpu_en & reg_we & (reg_addr == ADDR_PERIOD_HI);
  assign seq_reset = wr_hi;
  assign next_step = cpu_en & apu_cycle & (timer == 11'd0);
`ifdef APU_PULSE_SWEEP_EN
  sweep_cfg_t cfg;
  logic       wr_sw;
  assign wr_sw = cpu_en & reg_we & (reg_addr == ADDR_SWEEP);
  always_ff @(posedge clk) begin
    if (reset) cfg <= '0;
    else if (wr_sw) cfg <= sweep_cfg_t'(reg_wdata);
  end
  apu_sweep_unit #(.PULSE_CH(PULSE_CH)) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .half_frame(half_frame),
    .cfg_we    (wr_sw),
    .cfg       (cfg),
    .period    (period),
    .update    (upd),
    .target    (target),
    .mute      (mute)
  );
`else
  assign upd    = 1'b0;
  assign target = period;
  assign mute   = period < 11'd8;
`endif
  // register writes override the sweep result only for the bytes they touch
  assign base = upd ? target : period;
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= 11'd0;
      timer  <= 11'd0;
    end else if (cpu_en) begin
      period <= {wr_hi ? reg_wdata[2:0] : base[10:8], wr_lo ? reg_wdata : base[7:0]};
      if (apu_cycle) timer <= (timer == 11'd0) ? period : timer - 11'd1;
    end
  end
endmodule

// File: tb/tb_pulse_sweep_timer.sv
// tb_pulse_sweep_timer: randomized and directed checks of both pulse channel variants
module tb_pulse_sweep_timer;
  logic clk = 1'b0;
  logic reset, cpu_en, apu_cycle, half_frame, reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [1:0] ns, sr, mu;
  logic [10:0] per [2];
  int total = 0;
  int bad = 0;
`ifdef APU_PULSE_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  pulse_sweep_timer #(.PULSE_CH(1)) u1 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .apu_cycle(apu_cycle), .half_frame(half_frame),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .next_step(ns[0]), .seq_reset(sr[0]), .mute(mu[0]), .period(per[0])
  );
  pulse_sweep_timer #(.PULSE_CH(2)) u2 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .apu_cycle(apu_cycle), .half_frame(half_frame),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .next_step(ns[1]), .seq_reset(sr[1]), .mute(mu[1]), .period(per[1])
  );
  always #5 clk = ~clk;

  int m_per [2];
  int m_tim [2];
  int m_div, m_dp, m_sh;
  bit m_rel, m_ena, m_neg;

  function automatic int tgt(int c);
    int ch = m_per[c] >> m_sh;
    return (m_neg ? m_per[c] - ch - (c == 0 ? 1 : 0) : m_per[c] + ch) & 'hFFF;
  endfunction
  function automatic bit mmute(int c);
    return m_per[c] < 8 || (SW && !m_neg && tgt(c) > 'h7FF);
  endfunction
  function automatic bit mns(int c);
    return cpu_en && apu_cycle && m_tim[c] == 0;
  endfunction
  function automatic bit msr();
    return cpu_en && reg_we && reg_addr == 2'd3;
  endfunction

  task automatic drive(bit en, bit apu, bit hf, bit we, logic [1:0] a, logic [7:0] d);
    cpu_en = en; apu_cycle = apu; half_frame = hf; reg_we = we; reg_addr = a; reg_wdata = d;
    #3;
  endtask

  task automatic adv();
    int np;
    bit u;
    if (reset) begin
      m_per = '{0, 0}; m_tim = '{0, 0};
      m_div = 0; m_dp = 0; m_sh = 0; m_rel = 0; m_ena = 0; m_neg = 0;
    end else if (cpu_en) begin
      for (int c = 0; c < 2; c++) begin
        u = SW && half_frame && m_div == 0 && m_ena && m_sh != 0 && !mmute(c);
        np = u ? (tgt(c) & 'h7FF) : m_per[c];
        if (reg_we && reg_addr == 2'd2) np = (np & 'h700) | int'(reg_wdata);
        if (reg_we && reg_addr == 2'd3) np = (np & 'hFF) | ((int'(reg_wdata) & 7) << 8);
        if (apu_cycle) m_tim[c] = m_tim[c] == 0 ? m_per[c] : m_tim[c] - 1;
        m_per[c] = np;
      end
      if (half_frame) begin
        m_div = (m_div == 0 || m_rel) ? m_dp : m_div - 1;
        m_rel = 0;
      end
      if (SW && reg_we && reg_addr == 2'd1) begin
        m_ena = reg_wdata[7]; m_dp = int'(reg_wdata[6:4]); m_neg = reg_wdata[3];
        m_sh = int'(reg_wdata[2:0]); m_rel = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    drive(1, 0, 0, 1, a, d);
    adv();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1, 1, 1, 2'd2, 8'hFF);
    adv();
    adv();
    reset = 1'b0;
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (ns[c] !== 1'b0) begin bad++; $display("FAIL reset_next_step ch%0d got=%b exp=0", c, ns[c]); end
      total++; if (sr[c] !== 1'b0) begin bad++; $display("FAIL reset_seq_reset ch%0d got=%b exp=0", c, sr[c]); end
      total++; if (per[c] !== 11'd0) begin bad++; $display("FAIL reset_period ch%0d got=%h exp=0", c, per[c]); end
      total++; if (mu[c] !== 1'b1) begin bad++; $display("FAIL reset_mute ch%0d got=%b exp=1", c, mu[c]); end
    end
    adv();
  endtask

  task automatic test_timer();
    int cnt = 0;
    wr(2'd2, 8'd3);
    wr(2'd3, 8'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1, i[0], 0, 0, 2'd0, 8'h00);
      for (int c = 0; c < 2; c++) begin
        total++;
        if (ns[c] !== mns(c)) begin bad++; $display("FAIL timer_next_step ch%0d i=%0d got=%b exp=%b", c, i, ns[c], mns(c)); end
      end
      if (ns[0] === 1'b1) cnt++;
      adv();
    end
    total++;
    if (cnt != 4) begin bad++; $display("FAIL timer_pulse_count got=%0d exp=4", cnt); end
  endtask

  task automatic test_mute();
    wr(2'd2, 8'h07);
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (mu[c] !== 1'b1) begin bad++; $display("FAIL mute_low_period ch%0d got=%b exp=1", c, mu[c]); end
    end
    adv();
    wr(2'd2, 8'h08);
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (mu[c] !== 1'b0) begin bad++; $display("FAIL mute_period8 ch%0d got=%b exp=0", c, mu[c]); end
      total++; if (per[c] !== 11'h008) begin bad++; $display("FAIL period8 ch%0d got=%h exp=008", c, per[c]); end
    end
    adv();
  endtask

  task automatic test_gate();
    drive(0, 1, 1, 1, 2'd3, 8'h07);
    for (int c = 0; c < 2; c++) begin
      total++; if (sr[c] !== 1'b0 || ns[c] !== 1'b0) begin bad++; $display("FAIL gate_strobes ch%0d got=%b%b exp=00", c, sr[c], ns[c]); end
    end
    adv();
    drive(0, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (per[c] !== 11'h008) begin bad++; $display("FAIL gate_period ch%0d got=%h exp=008", c, per[c]); end
    end
    adv();
  endtask

  task automatic test_negate();
    logic [10:0] exp [2];
    exp[0] = 11'h07F;
    exp[1] = 11'h080;
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h89);
    drive(1, 0, 1, 0, 2'd0, 8'h00);
    adv();
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (per[c] !== exp[c]) begin bad++; $display("FAIL negate_target ch%0d got=%h exp=%h", c, per[c], exp[c]); end
    end
    adv();
  endtask

  task automatic test_overflow();
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h06);
    wr(2'd1, 8'h81);
    drive(1, 0, 1, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (mu[c] !== 1'b1) begin bad++; $display("FAIL overflow_mute ch%0d got=%b exp=1", c, mu[c]); end
    end
    adv();
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (per[c] !== 11'h600) begin bad++; $display("FAIL overflow_hold ch%0d got=%h exp=600", c, per[c]); end
    end
    adv();
  endtask

  task automatic test_divider();
    logic [10:0] exp [7];
    exp = '{11'h180, 11'h180, 11'h180, 11'h240, 11'h240, 11'h240, 11'h360};
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'hA1);
    for (int h = 0; h < 7; h++) begin
      drive(1, 0, 1, 0, 2'd0, 8'h00);
      adv();
      drive(1, 0, 0, 0, 2'd0, 8'h00);
      for (int c = 0; c < 2; c++) begin
        total++; if (per[c] !== exp[h]) begin bad++; $display("FAIL divider_hf%0d ch%0d got=%h exp=%h", h + 1, c, per[c], exp[h]); end
      end
      adv();
    end
  endtask

  task automatic test_collide();
    logic [10:0] exp = SW ? 11'h580 : 11'h500;
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h81);
    drive(1, 0, 1, 0, 2'd0, 8'h00);
    adv();
    drive(1, 0, 1, 1, 2'd3, 8'h05);
    for (int c = 0; c < 2; c++) begin
      total++; if (sr[c] !== 1'b1) begin bad++; $display("FAIL collide_seq_reset ch%0d got=%b exp=1", c, sr[c]); end
    end
    adv();
    drive(1, 0, 0, 0, 2'd0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      total++; if (sr[c] !== 1'b0) begin bad++; $display("FAIL collide_seq_reset_end ch%0d got=%b exp=0", c, sr[c]); end
      total++; if (per[c] !== exp) begin bad++; $display("FAIL collide_period ch%0d got=%h exp=%h", c, per[c], exp); end
    end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 8'($urandom));
      for (int c = 0; c < 2; c++) begin
        total++; if (ns[c] !== mns(c)) begin bad++; $display("FAIL rnd_next_step ch%0d i=%0d got=%b exp=%b", c, i, ns[c], mns(c)); end
        total++; if (sr[c] !== msr()) begin bad++; $display("FAIL rnd_seq_reset ch%0d i=%0d got=%b exp=%b", c, i, sr[c], msr()); end
        total++; if (mu[c] !== mmute(c)) begin bad++; $display("FAIL rnd_mute ch%0d i=%0d got=%b exp=%b", c, i, mu[c], mmute(c)); end
        total++; if (per[c] !== 11'(m_per[c])) begin bad++; $display("FAIL rnd_period ch%0d i=%0d got=%h exp=%h", c, i, per[c], 11'(m_per[c])); end
      end
      adv();
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_en = 1'b0; apu_cycle = 1'b0; half_frame = 1'b0; reg_we = 1'b0;
    reg_addr = 2'd0; reg_wdata = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_timer();
    test_mute();
    test_gate();
    if (SW) begin
      test_negate();
      test_overflow();
      test_divider();
    end
    test_collide();
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_sweep_timer.md
PULSE_SWEEP_TIMER -- requirements
Module: pulse_sweep_timer

Interface
REQ-001 SHALL have parameter PULSE_CH, default 1, selecting channel: 1 = ones'-complement negate, 2 = two's-complement negate.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_en  input  1  CPU-cycle enable; all state changes qualified by it.
REQ-005 SHALL have port apu_cycle  input  1  APU tick (every other CPU cycle), valid with cpu_en.
REQ-006 SHALL have port half_frame  input  1  frame-counter half-frame strobe, valid with cpu_en.
REQ-007 SHALL have port reg_we  input  1  register write strobe.
REQ-008 SHALL have port reg_addr  input  2  register select: 1 = sweep, 2 = period low, 3 = period high; 0 ignored.
REQ-009 SHALL have port reg_wdata  input  8  write data.
REQ-010 SHALL have port next_step  output  1  sequencer advance strobe.
REQ-011 SHALL have port seq_reset  output  1  sequencer restart strobe.
REQ-012 SHALL have port mute  output  1  channel silence request.
REQ-013 SHALL have port period  output  11  current timer period.

Function
REQ-014 Write addr 2 SHALL load period[7:0]; write addr 3 SHALL load period[10:8] from reg_wdata[2:0].
REQ-015 seq_reset SHALL be combinational: cpu_en & reg_we & (reg_addr==3).
REQ-016 Write addr 1 SHALL load enable=bit7, div_period=bits6:4, negate=bit3, shift=bits2:0, and set reload flag.
REQ-017 On cpu_en & apu_cycle: timer==0 -> timer <= period; else timer <= timer-1.
REQ-018 next_step SHALL be combinational: cpu_en & apu_cycle & (timer==0); zero-latency, one-cycle strobe.
REQ-019 change = period >> shift; target = period + change, or when negate: period - change - 1 (PULSE_CH=1) / period - change (PULSE_CH=2), computed 12 bits wide.
REQ-020 mute SHALL be combinational: (period < 8) | (!negate & target > 0x7FF), independent of enable.
REQ-021 On cpu_en & half_frame: if divider==0 & enable & shift!=0 & !mute -> period <= target[10:0].
REQ-022 On cpu_en & half_frame: if divider==0 | reload -> divider <= div_period, reload cleared; else divider <= divider-1.
REQ-023 Period register write and sweep update in same enabled cycle: written byte SHALL win for its bits; other bits keep pre-update value.
REQ-024 Sweep register write coinciding with half_frame: new fields take effect from next cycle; reload SHALL remain set.
REQ-025 Negate underflow (PULSE_CH=1, period=0, shift=0 not updated) SHALL wrap in 12-bit target, no mute from target.
REQ-026 Nothing SHALL change when cpu_en=0.

Reset
REQ-027 reset SHALL clear period, timer, divider, all sweep fields and reload to 0, regardless of cpu_en.
REQ-028 After reset: next_step=0, seq_reset=0, period=0, mute=1.

Configuration
REQ-029 Macro APU_PULSE_SWEEP_EN defined: sweep unit present per REQ-016..REQ-025.
REQ-030 APU_PULSE_SWEEP_EN undefined: addr-1 writes ignored, period never changed by half_frame, mute = (period < 8) only.

Structure
REQ-031 Package apu_pkg SHALL hold sweep config struct (enable, div_period, negate, shift) and register address constants.
REQ-032 Sweep target/mute/divider logic SHALL be a sub-module apu_sweep_unit; timer and registers stay in top.

Verification
REQ-033 period=3, apu_cycle every 2 cpu_en cycles -> next_step once per 4 apu_cycles, timer 3,2,1,0.
REQ-034 period=7 -> mute=1; write period low 0x08 -> mute=0 next cycle.
REQ-035 period=0x100, shift=1, negate: PULSE_CH=1 target=0x07F, PULSE_CH=2 target=0x080.
REQ-036 period=0x600, shift=1, no negate -> target=0x900, mute=1, half_frame leaves period 0x600.
REQ-037 period=0x100, enable, div_period=2, shift=1 -> updates on half_frames 1,4,7: 0x180, 0x240, 0x360.
REQ-038 Write addr 3 data 0x05 same cycle as sweep update -> seq_reset=1 for one cycle, period[10:8]=5, period[7:0] from sweep target.
